sha256_padder: RTL and testbench

Message-side feeder for the `sha256` core. It accepts a byte-length-announced message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: the 0x80 marker, zero fill, and the 64-bit bit-length. It presents successive 512-bit blocks plus the total block count on the core's `message`/`block` inputs, and advances one block per `next_block_read_rdy` pulse from the core.

---
 rtl/sha256_padder_if.sv | 32 +++
 rtl/sha256_padder.sv | 176 +++++++++++++++++
 tb/tb_sha256_padder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_padder_if.sv
`default_nettype none
// =============================================================================
// sha256_padder_if: message-stream and block-presentation bus of sha256_padder.
// Revision 1.0
// =============================================================================
interface sha256_padder_if #(
   parameter int LEN_W = 64
) ();
   logic             start;
   logic [LEN_W-1:0] msg_len;
   logic [31:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic [511:0]     message;
   logic [LEN_W-1:0] block;
   logic             blk_valid;
   logic             next_block_read_rdy;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, msg_len, in_data, in_valid, next_block_read_rdy,
      input  in_ready, message, block, blk_valid, busy, done, err
   );

   modport slave (
      input  start, msg_len, in_data, in_valid, next_block_read_rdy,
      output in_ready, message, block, blk_valid, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// =============================================================================
// sha256_padder: FIPS 180-4 padder turning a 32-bit word stream into 512-bit blocks.
// Revision 1.0
// =============================================================================
module sha256_padder #(
   parameter int LEN_W = 64
) (
   input  logic           clk,
   input  logic           rst,
   sha256_padder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_PAD  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [15:0][31:0] r_msg, w_msg_nxt;
   logic [LEN_W-1:0]  r_rem, w_rem_nxt;
   logic [3:0]        r_widx, w_widx_nxt;
   logic [LEN_W-1:0]  r_bidx, w_bidx_nxt;
   logic              r_mark, w_mark_nxt;
   logic [LEN_W-1:0]  r_block, w_block_nxt;
   logic [63:0]       r_bitlen, w_bitlen_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              r_err, w_err_nxt;

   logic [31:0]       w_word;
   logic [3:0]        w_slot;
   logic              w_final;

   // Word 0 sits in the top 32 bits, so slot n maps to packed index 15-n.
   assign w_slot  = 4'd15 - r_widx;
   assign w_final = (r_bidx == r_block - LEN_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_msg    <= '0;
         r_rem    <= '0;
         r_widx   <= '0;
         r_bidx   <= '0;
         r_mark   <= 1'b0;
         r_block  <= '0;
         r_bitlen <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_msg    <= w_msg_nxt;
         r_rem    <= w_rem_nxt;
         r_widx   <= w_widx_nxt;
         r_bidx   <= w_bidx_nxt;
         r_mark   <= w_mark_nxt;
         r_block  <= w_block_nxt;
         r_bitlen <= w_bitlen_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_msg_nxt    = r_msg;
      w_rem_nxt    = r_rem;
      w_widx_nxt   = r_widx;
      w_bidx_nxt   = r_bidx;
      w_mark_nxt   = r_mark;
      w_block_nxt  = r_block;
      w_bitlen_nxt = r_bitlen;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_err_nxt    = r_err;
      w_word       = 32'h0;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_block_nxt  = ((bus.msg_len + LEN_W'(8)) >> 6) + LEN_W'(1);
               w_bitlen_nxt = 64'(bus.msg_len) << 3;
               w_rem_nxt    = bus.msg_len;
               w_widx_nxt   = 4'd0;
               w_bidx_nxt   = '0;
               w_mark_nxt   = 1'b0;
               w_msg_nxt    = '0;
               w_busy_nxt   = 1'b1;
               w_err_nxt    = 1'b0;
               w_state_nxt  = (bus.msg_len != '0) ? S_FILL : S_PAD;
            end
         end
         S_FILL: begin
            if (bus.in_valid) begin
               if (r_rem >= LEN_W'(4)) begin
                  w_word    = bus.in_data;
                  w_rem_nxt = r_rem - LEN_W'(4);
               end else begin
                  // Partial last word: trailing bytes become the 0x80 marker and zeros.
                  case (r_rem[1:0])
                     2'd1:    w_word = {bus.in_data[31:24], 8'h80, 16'h0000};
                     2'd2:    w_word = {bus.in_data[31:16], 8'h80, 8'h00};
                     2'd3:    w_word = {bus.in_data[31:8], 8'h80};
                     default: w_word = 32'h8000_0000;
                  endcase
                  w_mark_nxt = 1'b1;
                  w_rem_nxt  = '0;
               end
               w_msg_nxt[w_slot] = w_word;
               w_widx_nxt        = r_widx + 4'd1;
               if (r_widx == 4'd15) begin
                  w_state_nxt = S_HOLD;
               end else if (w_rem_nxt == '0) begin
                  w_state_nxt = S_PAD;
               end
            end
         end
         S_PAD: begin
            if (!r_mark) begin
               w_word     = 32'h8000_0000;
               w_mark_nxt = 1'b1;
            end else if (w_final && r_widx == 4'd14) begin
               w_word = r_bitlen[63:32];
            end else if (w_final && r_widx == 4'd15) begin
               w_word = r_bitlen[31:0];
            end
            w_msg_nxt[w_slot] = w_word;
            w_widx_nxt        = r_widx + 4'd1;
            if (r_widx == 4'd15) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.next_block_read_rdy) begin
               w_bidx_nxt = r_bidx + LEN_W'(1);
               if (w_final) begin
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_msg_nxt   = '0;
                  w_widx_nxt  = 4'd0;
                  w_state_nxt = (r_rem != '0) ? S_FILL : S_PAD;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Protocol violations never alter the datapath, they only latch err.
      if (bus.start && r_busy) begin
         w_err_nxt = 1'b1;
      end
      if (bus.next_block_read_rdy && r_state != S_HOLD) begin
         w_err_nxt = 1'b1;
      end
      if (bus.in_valid && r_state != S_FILL) begin
         w_err_nxt = 1'b1;
      end
   end

   assign bus.in_ready  = (r_state == S_FILL);
   assign bus.blk_valid = (r_state == S_HOLD);
   assign bus.message   = r_msg;
   assign bus.block     = r_block;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// =============================================================================
// tb_sha256_padder: randomized bench comparing padder blocks to a byte-level padding model.
// Revision 1.0
// =============================================================================
module tb_sha256_padder;
   localparam int LEN_W = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [7:0]   msgb [0:255];
   logic [7:0]   pad  [0:319];
   int           exp_nb;
   logic         exp_err;
   logic [511:0] last_msg;
   int           lat;

   sha256_padder_if #(.LEN_W(LEN_W)) bus ();
   sha256_padder #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random;
      for (int i = 0; i < 256; i++) msgb[i] = 8'($urandom);
   endtask

   // Padded byte image: message, 0x80, zeros, 64-bit big-endian bit length.
   task automatic build_model(input int len);
      logic [63:0] bits;
      exp_nb = (len + 9 + 63) / 64;
      for (int i = 0; i < 320; i++) pad[i] = 8'h00;
      for (int i = 0; i < len; i++) pad[i] = msgb[i];
      pad[len] = 8'h80;
      bits = 64'(len) * 64'd8;
      for (int k = 0; k < 8; k++) pad[exp_nb * 64 - 1 - k] = bits[8 * k +: 8];
   endtask

   function automatic logic [511:0] exp_block(input int b);
      logic [511:0] v = '0;
      for (int j = 0; j < 64; j++) v = {v[503:0], pad[64 * b + j]};
      return v;
   endfunction

   task automatic run_msg(input int len, input int stall, input bit inject, input bit sof);
      int nw = (len + 3) / 4;
      int wi = 0;
      int t;
      bit tog = 1'b0;
      logic [511:0] expv;
      bit fin;
      build_model(len);
      bus.in_valid = 1'b0;
      bus.next_block_read_rdy = 1'b0;
      bus.start = 1'b1;
      bus.msg_len = 64'(len);
      step;
      bus.start = 1'b0;
      lat = 1;
      checks++;
      if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL start_state len=%0d busy=%b err=%b required busy=1 err=0", len, bus.busy, bus.err);
      end
      exp_err = 1'b0;
      for (int b = 0; b < exp_nb; b++) begin
         t = 0;
         while (bus.blk_valid !== 1'b1 && t < 400) begin
            bus.in_valid = 1'b0;
            bus.start = 1'b0;
            if (bus.in_ready === 1'b1 && wi < nw) begin
               bit go;
               go = (stall == 0) || (stall == 1 && tog) || (stall == 2 && $urandom_range(0, 2) != 0);
               tog = ~tog;
               if (go) begin
                  bus.in_valid = 1'b1;
                  bus.in_data = {msgb[4 * wi], msgb[4 * wi + 1], msgb[4 * wi + 2], msgb[4 * wi + 3]};
                  wi++;
                  if (inject && wi == 2) begin
                     bus.start = 1'b1;
                     bus.msg_len = 64'd1000;
                     exp_err = 1'b1;
                  end
               end
            end
            step;
            t++;
            if (b == 0) lat++;
         end
         bus.in_valid = 1'b0;
         bus.start = 1'b0;
         checks++;
         if (bus.blk_valid !== 1'b1) begin
            failures++;
            $display("FAIL blk_timeout len=%0d block=%0d blk_valid=%b required 1", len, b, bus.blk_valid);
            return;
         end
         expv = exp_block(b);
         checks++;
         if (bus.message !== expv || bus.block !== 64'(exp_nb) || bus.err !== exp_err) begin
            failures++;
            $display("FAIL block_content len=%0d blk=%0d got msg=%h cnt=%0d err=%b required msg=%h cnt=%0d err=%b",
                     len, b, bus.message, bus.block, bus.err, expv, exp_nb, exp_err);
         end
         last_msg = bus.message;
         repeat ($urandom_range(0, 2)) step;
         fin = (b == exp_nb - 1);
         bus.next_block_read_rdy = 1'b1;
         if (sof && fin) begin
            bus.start = 1'b1;
            bus.msg_len = 64'd3;
            exp_err = 1'b1;
         end
         step;
         bus.next_block_read_rdy = 1'b0;
         bus.start = 1'b0;
         checks++;
         if (bus.blk_valid !== 1'b0 || bus.done !== fin || bus.busy !== !fin || bus.err !== exp_err) begin
            failures++;
            $display("FAIL consume len=%0d blk=%0d got valid=%b done=%b busy=%b err=%b required valid=0 done=%b busy=%b err=%b",
                     len, b, bus.blk_valid, bus.done, bus.busy, bus.err, fin, !fin, exp_err);
         end
      end
      step;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse len=%0d got done=%b busy=%b required done=0 busy=0", len, bus.done, bus.busy);
      end
   endtask

   task automatic test_reset;
      repeat (3) step;
      checks++;
      if (bus.message !== '0 || bus.block !== '0 || bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_values got rdy=%b valid=%b busy=%b done=%b err=%b block=%0d required all 0",
                  bus.in_ready, bus.blk_valid, bus.busy, bus.done, bus.err, bus.block);
      end
      rst = 1'b1;
      step;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got rdy=%b valid=%b busy=%b required 0", bus.in_ready, bus.blk_valid, bus.busy);
      end
   endtask

   task automatic test_abc;
      msgb[0] = 8'h61; msgb[1] = 8'h62; msgb[2] = 8'h63; msgb[3] = 8'h00;
      run_msg(3, 0, 1'b0, 1'b0);
      checks++;
      if (last_msg[511:480] !== 32'h61626380 || last_msg[31:0] !== 32'h00000018 || lat !== 17) begin
         failures++;
         $display("FAIL abc got w0=%h w15=%h lat=%0d required w0=61626380 w15=00000018 lat=17",
                  last_msg[511:480], last_msg[31:0], lat);
      end
   endtask

   task automatic test_empty;
      fill_random();
      run_msg(0, 0, 1'b0, 1'b0);
      checks++;
      if (last_msg[511:480] !== 32'h80000000 || last_msg[479:0] !== '0 || lat !== 17) begin
         failures++;
         $display("FAIL empty got w0=%h lat=%0d required w0=80000000 rest=0 lat=17", last_msg[511:480], lat);
      end
   endtask

   task automatic test_len56;
      for (int i = 0; i < 256; i++) msgb[i] = 8'h41;
      run_msg(56, 0, 1'b0, 1'b0);
      checks++;
      if (last_msg !== {480'h0, 32'h000001C0}) begin
         failures++;
         $display("FAIL len56_final got %h required word15=000001c0 rest 0", last_msg);
      end
   endtask

   task automatic test_len64_backpressure;
      fill_random();
      run_msg(64, 1, 1'b0, 1'b0);
      checks++;
      if (last_msg[511:480] !== 32'h80000000 || last_msg[31:0] !== 32'h00000200) begin
         failures++;
         $display("FAIL len64_final got w0=%h w15=%h required w0=80000000 w15=00000200",
                  last_msg[511:480], last_msg[31:0]);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 8; n++) begin
         fill_random();
         run_msg(int'($urandom_range(0, 200)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end
   endtask

   task automatic test_errors;
      bus.next_block_read_rdy = 1'b1;
      step;
      bus.next_block_read_rdy = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rdy_in_idle got err=%b busy=%b valid=%b rdy=%b required err=1 others 0",
                  bus.err, bus.busy, bus.blk_valid, bus.in_ready);
      end
      fill_random();
      run_msg(8, 0, 1'b1, 1'b0);
      fill_random();
      run_msg(4, 2, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      step;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL valid_in_idle got err=%b busy=%b required err=1 busy=0", bus.err, bus.busy);
      end
   endtask

   task automatic test_back_to_back;
      fill_random();
      run_msg(5, 0, 1'b0, 1'b1);
      fill_random();
      run_msg(int'($urandom_range(50, 130)), 2, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid;
      fill_random();
      bus.start = 1'b1;
      bus.msg_len = 64'd40;
      step;
      bus.start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = $urandom;
         step;
      end
      bus.in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (bus.message !== '0 || bus.block !== '0 || bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got rdy=%b valid=%b busy=%b block=%0d required all 0",
                  bus.in_ready, bus.blk_valid, bus.busy, bus.block);
      end
      #1 rst = 1'b1;
      step;
      test_abc();
   endtask

   initial begin
      bus.start = 1'b0;
      bus.msg_len = '0;
      bus.in_data = '0;
      bus.in_valid = 1'b0;
      bus.next_block_read_rdy = 1'b0;
      test_reset();
      test_abc();
      test_empty();
      test_len56();
      test_len64_backpressure();
      test_random();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
